// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared encodings for the two-requester APB master front-end
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_SLVERR  = 2'b01,
        RSP_TIMEOUT = 2'b10,
        RSP_BADSEL  = 2'b11
    } rsp_code_e;

    localparam logic [1:0] SEL_GPIO = 2'b01;
    localparam logic [1:0] SEL_UART = 2'b10;

    // Only the two one-hot slave codes map onto a real PSEL line
    function automatic logic sel_is_legal(input logic [1:0] sel);
        return (sel == SEL_GPIO) || (sel == SEL_UART);
    endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin arbiter; rrPtr_q names the requester favoured on a tie
module apb_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic rrPtr_q;

    // One-hot grant: a lone requester always wins, a tie goes to rrPtr_q
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rrPtr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // After any accepted grant the pointer moves to the requester that was not served
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rrPtr_q <= 1'b0;
        end else if (advance_i && (grant_o != 2'b00)) begin
            rrPtr_q <= grant_o[0];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus between two requesters with a bounded ACCESS phase
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [3:0]  req_slave,
    input  logic [9:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_accept,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [1:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [4:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    apb_state_e      state_q;
    logic            owner_q;
    logic [TO_W-1:0] toCnt_q;
    logic [1:0]      reqAccept_q;
    logic [1:0]      rspValid_q;
    logic [1:0]      rspErr_q;
    logic [31:0]     rspRdata_q;
    logic [1:0]      psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [4:0]      paddr_q;
    logic [31:0]     pwdata_q;

    logic [1:0]      grant;
    logic            arbAdvance;
    logic [1:0]      ownerMask;
    logic            gntWrite_d;
    logic [1:0]      gntSlave_d;
    logic [4:0]      gntAddr_d;
    logic [31:0]     gntWdata_d;

    assign arbAdvance = (state_q == ST_IDLE);
    assign ownerMask  = owner_q ? 2'b10 : 2'b01;

    apb_rr_arb2 u_arb (
        .clk_i     (pclk),
        .rst_n_i   (Reset),
        .valid_i   (req_valid),
        .advance_i (arbAdvance),
        .grant_o   (grant)
    );

    // Steer the granted requester's fields toward the request latch
    always_comb begin
        gntWrite_d = grant[1] ? req_write[1]      : req_write[0];
        gntSlave_d = grant[1] ? req_slave[3:2]    : req_slave[1:0];
        gntAddr_d  = grant[1] ? req_addr[9:5]     : req_addr[4:0];
        gntWdata_d = grant[1] ? req_wdata[63:32]  : req_wdata[31:0];
    end

    // Bus sequencing FSM; the APB registers double as the request latch
    always_ff @(posedge pclk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            toCnt_q     <= '0;
            reqAccept_q <= '0;
            rspValid_q  <= '0;
            rspErr_q    <= RSP_OK;
            rspRdata_q  <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            reqAccept_q <= '0;
            rspValid_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        reqAccept_q <= grant;
                        owner_q     <= grant[1];
                        if (sel_is_legal(gntSlave_d)) begin
                            psel_q    <= gntSlave_d;
                            pwrite_q  <= gntWrite_d;
                            paddr_q   <= gntAddr_d;
                            pwdata_q  <= gntWdata_d;
                            penable_q <= 1'b0;
                            state_q   <= ST_SETUP;
                        end else begin
                            rspValid_q <= grant;
                            rspErr_q   <= RSP_BADSEL;
                            rspRdata_q <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    toCnt_q   <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel_q     <= '0;
                        penable_q  <= 1'b0;
                        rspValid_q <= ownerMask;
                        rspErr_q   <= pslverr ? RSP_SLVERR : RSP_OK;
                        rspRdata_q <= pwrite_q ? 32'h0 : prdata;
                        state_q    <= ST_IDLE;
                    end else if (toCnt_q == TO_LAST) begin
                        psel_q     <= '0;
                        penable_q  <= 1'b0;
                        rspValid_q <= ownerMask;
                        rspErr_q   <= RSP_TIMEOUT;
                        rspRdata_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_accept = reqAccept_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_rdata  = rspRdata_q;
    assign rsp_err    = rspErr_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed stimulus checked against a transaction-level timing model
module tb_apb_master_arbiter;

    localparam int TIMEOUT_CYC = 16;
    localparam int MAXC        = 2048;

    logic        pclk     = 1'b0;
    logic        Reset    = 1'b0;
    logic [1:0]  reqValid = '0;
    logic [1:0]  reqWrite = '0;
    logic [3:0]  reqSlave = '0;
    logic [9:0]  reqAddr  = '0;
    logic [63:0] reqWdata = '0;
    logic [1:0]  reqAccept;
    logic [1:0]  rspValid;
    logic [31:0] rspRdata;
    logic [1:0]  rspErr;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata   = '0;
    logic        pready   = 1'b0;
    logic        pslverr  = 1'b0;

    typedef struct packed {
        logic        write;
        logic [1:0]  slave;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } req_t;

    req_t reqQ0[$];
    req_t reqQ1[$];

    int          slvWait[2];
    bit          slvErr[2];
    bit          slvNever[2];
    int          accCnt = 0;
    logic [31:0] slvMem[2][32];
    logic [31:0] mdlMem[2][32];

    logic [1:0]  expAcc[MAXC];
    logic [1:0]  expRsp[MAXC];
    logic [1:0]  expErr[MAXC];
    logic [31:0] expRd[MAXC];
    logic [1:0]  expPsel[MAXC];
    logic        expPen[MAXC];
    logic        expWrite[MAXC];
    logic [4:0]  expAddr[MAXC];
    logic [31:0] expWdata[MAXC];
    int          cyc    = 0;
    int          freeAt = 0;
    bit          rrPtr  = 1'b0;

    int          accCyc[2];
    int          rspCyc[2];
    logic [1:0]  lastErr[2];
    logic [31:0] lastRd[2];
    int          gntLog[$];
    bit          seenPsel = 1'b0;
    logic [1:0]  lastPsel = '0;

    int          total = 0;
    int          bad   = 0;

    apb_master_arbiter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (5)
    ) dut (
        .pclk       (pclk),
        .Reset      (Reset),
        .req_valid  (reqValid),
        .req_write  (reqWrite),
        .req_slave  (reqSlave),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_accept (reqAccept),
        .rsp_valid  (rspValid),
        .rsp_rdata  (rspRdata),
        .rsp_err    (rspErr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic boundExpired(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input int who, input logic wr, input logic [1:0] sl,
                                 input logic [4:0] ad, input logic [31:0] wd);
        req_t r;
        r.write = wr;
        r.slave = sl;
        r.addr  = ad;
        r.wdata = wd;
        if (who == 0) reqQ0.push_back(r);
        else          reqQ1.push_back(r);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while ((reqQ0.size() != 0 || reqQ1.size() != 0 || cyc <= freeAt) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        if (n >= budget) boundExpired(name);
    endtask

    // Transaction-level model: picks the winner and derives every completion time arithmetically
    always @(posedge pclk) begin : model
        int          g;
        int          si;
        int          done;
        logic [1:0]  sel;
        logic [1:0]  err;
        logic [4:0]  ad;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        wr;
        cyc++;
        if (!Reset) begin
            for (int t = cyc; t < MAXC; t++) begin
                expAcc[t] = '0; expRsp[t] = '0; expErr[t] = '0; expRd[t] = '0;
                expPsel[t] = '0; expPen[t] = 1'b0; expWrite[t] = 1'b0;
                expAddr[t] = '0; expWdata[t] = '0;
            end
            freeAt = 0;
            rrPtr  = 1'b0;
        end else if (cyc >= freeAt && reqValid != 2'b00 && cyc < MAXC - 40) begin
            g     = (reqValid == 2'b11) ? int'(rrPtr) : (reqValid[1] ? 1 : 0);
            rrPtr = (g == 0);
            sel   = reqSlave[g*2 +: 2];
            ad    = reqAddr[g*5 +: 5];
            wd    = reqWdata[g*32 +: 32];
            wr    = reqWrite[g];
            expAcc[cyc][g] = 1'b1;
            if (sel != 2'b01 && sel != 2'b10) begin
                expRsp[cyc][g] = 1'b1;
                expErr[cyc]    = 2'b11;
                expRd[cyc]     = '0;
                freeAt         = cyc + 1;
            end else begin
                si = sel[1] ? 1 : 0;
                if (slvNever[si] || slvWait[si] >= TIMEOUT_CYC) begin
                    done = cyc + 1 + TIMEOUT_CYC;
                    err  = 2'b10;
                    rd   = '0;
                end else begin
                    done = cyc + 2 + slvWait[si];
                    err  = slvErr[si] ? 2'b01 : 2'b00;
                    rd   = wr ? 32'h0 : mdlMem[si][ad];
                    if (wr) mdlMem[si][ad] = wd;
                end
                for (int t = cyc; t < done; t++) begin
                    expPsel[t]  = sel;
                    expAddr[t]  = ad;
                    expWrite[t] = wr;
                    expWdata[t] = wd;
                    expPen[t]   = (t > cyc);
                end
                expRsp[done][g] = 1'b1;
                expErr[done]    = err;
                expRd[done]     = rd;
                freeAt          = done + 1;
            end
        end
    end

    // Per-cycle comparison of the registered outputs against the model, plus event capture
    always @(negedge pclk) begin
        if (!Reset) begin
            checkOutput("reset_quiet", {25'd0, reqAccept, rspValid, psel, penable}, 32'h0);
        end else if (cyc < MAXC) begin
            checkOutput("req_accept", reqAccept, expAcc[cyc]);
            checkOutput("rsp_valid", rspValid, expRsp[cyc]);
            checkOutput("psel", psel, expPsel[cyc]);
            checkOutput("penable", penable, expPen[cyc]);
            if (expRsp[cyc] != 2'b00) begin
                checkOutput("rsp_err", rspErr, expErr[cyc]);
                checkOutput("rsp_rdata", rspRdata, expRd[cyc]);
            end
            if (expPsel[cyc] != 2'b00) begin
                checkOutput("paddr", paddr, expAddr[cyc]);
                checkOutput("pwrite", pwrite, expWrite[cyc]);
                checkOutput("pwdata", pwdata, expWdata[cyc]);
            end
            for (int i = 0; i < 2; i++) begin
                if (reqAccept[i]) begin
                    accCyc[i] = cyc;
                    gntLog.push_back(i);
                end
                if (rspValid[i]) begin
                    rspCyc[i]  = cyc;
                    lastErr[i] = rspErr;
                    lastRd[i]  = rspRdata;
                end
            end
            if (psel != 2'b00) begin
                seenPsel = 1'b1;
                lastPsel = psel;
            end
        end
    end

    // Requester drivers: present the queue head, retire it once the DUT accepts
    always @(negedge pclk) begin
        if (reqValid[0] && reqAccept[0] && reqQ0.size() > 0) reqQ0.delete(0);
        if (reqValid[1] && reqAccept[1] && reqQ1.size() > 0) reqQ1.delete(0);
        if (reqQ0.size() > 0) begin
            reqValid[0]     = 1'b1;
            reqWrite[0]     = reqQ0[0].write;
            reqSlave[1:0]   = reqQ0[0].slave;
            reqAddr[4:0]    = reqQ0[0].addr;
            reqWdata[31:0]  = reqQ0[0].wdata;
        end else begin
            reqValid[0] = 1'b0;
        end
        if (reqQ1.size() > 0) begin
            reqValid[1]     = 1'b1;
            reqWrite[1]     = reqQ1[0].write;
            reqSlave[3:2]   = reqQ1[0].slave;
            reqAddr[9:5]    = reqQ1[0].addr;
            reqWdata[63:32] = reqQ1[0].wdata;
        end else begin
            reqValid[1] = 1'b0;
        end
    end

    // Slave model: GPIO is index 0, UART index 1, each with its own wait/error setting
    always @(negedge pclk) begin : slave
        int s;
        if (psel != 2'b00 && penable) begin
            s       = psel[1] ? 1 : 0;
            pready  = !slvNever[s] && (accCnt == slvWait[s]);
            pslverr = pready && slvErr[s];
            prdata  = slvMem[s][paddr];
            if (pready && pwrite) slvMem[s][paddr] = pwdata;
            accCnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = '0;
            accCnt  = 0;
        end
    end

    // Guard against a hung simulation
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence with hand-computed expectations
    initial begin : main
        int n;
        int prevRsp;
        for (int s = 0; s < 2; s++) begin
            slvWait[s] = 0; slvErr[s] = 1'b0; slvNever[s] = 1'b0;
            accCyc[s] = 0; rspCyc[s] = 0; lastErr[s] = '0; lastRd[s] = '0;
            for (int a = 0; a < 32; a++) begin
                slvMem[s][a] = 32'hC0DE0000 | (s << 8) | a;
                mdlMem[s][a] = 32'hC0DE0000 | (s << 8) | a;
            end
        end
        for (int t = 0; t < MAXC; t++) begin
            expAcc[t] = '0; expRsp[t] = '0; expErr[t] = '0; expRd[t] = '0;
            expPsel[t] = '0; expPen[t] = 1'b0; expWrite[t] = 1'b0;
            expAddr[t] = '0; expWdata[t] = '0;
        end

        Reset = 1'b0;
        #12;
        checkOutput("por_psel", psel, 0);
        checkOutput("por_penable", penable, 0);
        checkOutput("por_ctrl", {pwrite, paddr}, 0);
        checkOutput("por_pwdata", pwdata, 0);
        checkOutput("por_rsp", {reqAccept, rspValid, rspErr}, 0);
        checkOutput("por_rdata", rspRdata, 0);
        @(negedge pclk);
        @(negedge pclk);
        Reset = 1'b1;

        $display("[TB] contention on UART");
        gntLog.delete();
        applyStimulus(0, 1'b1, 2'b10, 5'd0, 32'h11110000);
        applyStimulus(0, 1'b0, 2'b10, 5'd0, 32'h00000000);
        applyStimulus(1, 1'b1, 2'b10, 5'd2, 32'h22220002);
        applyStimulus(1, 1'b0, 2'b10, 5'd2, 32'h00000000);
        waitIdle("contention_idle", 200);
        checkOutput("cont_grants", gntLog.size(), 4);
        if (gntLog.size() == 4) begin
            checkOutput("cont_order", {gntLog[0][3:0], gntLog[1][3:0], gntLog[2][3:0], gntLog[3][3:0]}, 16'h0101);
        end
        checkOutput("cont_rd0", lastRd[0], 32'h11110000);
        checkOutput("cont_rd1", lastRd[1], 32'h22220002);
        checkOutput("cont_spacing", accCyc[1] - accCyc[0], 3);

        $display("[TB] basic GPIO write/read");
        applyStimulus(0, 1'b1, 2'b01, 5'd1, 32'hABCD1234);
        waitIdle("basic_wr_idle", 50);
        checkOutput("basic_wr_lat", rspCyc[0] - accCyc[0], 2);
        checkOutput("basic_wr_err", lastErr[0], 2'b00);
        checkOutput("basic_psel", lastPsel, 2'b01);
        applyStimulus(0, 1'b0, 2'b01, 5'd1, 32'h00000000);
        waitIdle("basic_rd_idle", 50);
        checkOutput("basic_rd_lat", rspCyc[0] - accCyc[0], 2);
        checkOutput("basic_rd_data", lastRd[0], 32'hABCD1234);

        $display("[TB] wait states with slave error");
        slvWait[1] = 5;
        slvErr[1]  = 1'b1;
        applyStimulus(1, 1'b0, 2'b10, 5'd3, 32'h00000000);
        waitIdle("wait_idle", 60);
        checkOutput("wait_lat", rspCyc[1] - accCyc[1], 7);
        checkOutput("wait_err", lastErr[1], 2'b01);
        checkOutput("wait_rd", lastRd[1], 32'hC0DE0103);
        slvWait[1] = 0;
        slvErr[1]  = 1'b0;

        $display("[TB] timeout with a queued follower");
        slvNever[0] = 1'b1;
        applyStimulus(0, 1'b1, 2'b01, 5'd4, 32'hDEAD0004);
        applyStimulus(1, 1'b0, 2'b10, 5'd2, 32'h00000000);
        waitIdle("timeout_idle", 200);
        checkOutput("to_lat", rspCyc[0] - accCyc[0], 17);
        checkOutput("to_err", lastErr[0], 2'b10);
        checkOutput("to_rd", lastRd[0], 32'h0);
        checkOutput("to_next_gap", rspCyc[1] - rspCyc[0], 3);
        checkOutput("to_next_rd", lastRd[1], 32'h22220002);
        slvNever[0] = 1'b0;

        $display("[TB] pready on the last allowed ACCESS cycle");
        slvWait[0] = 15;
        applyStimulus(0, 1'b0, 2'b01, 5'd4, 32'h00000000);
        waitIdle("edge_idle", 100);
        checkOutput("edge_lat", rspCyc[0] - accCyc[0], 17);
        checkOutput("edge_err", lastErr[0], 2'b00);
        checkOutput("edge_rd", lastRd[0], 32'hC0DE0004);
        slvWait[0] = 0;

        $display("[TB] illegal slave selects");
        seenPsel = 1'b0;
        applyStimulus(1, 1'b1, 2'b11, 5'd7, 32'h00000077);
        applyStimulus(0, 1'b0, 2'b00, 5'd3, 32'h00000000);
        waitIdle("illegal_idle", 50);
        checkOutput("ill_no_psel", seenPsel, 1'b0);
        checkOutput("ill_lat1", rspCyc[1] - accCyc[1], 0);
        checkOutput("ill_lat0", rspCyc[0] - accCyc[0], 0);
        checkOutput("ill_err1", lastErr[1], 2'b11);
        checkOutput("ill_err0", lastErr[0], 2'b11);
        checkOutput("ill_rd0", lastRd[0], 32'h0);
        checkOutput("ill_regrant", accCyc[0] - accCyc[1], 1);

        $display("[TB] reset during ACCESS");
        slvWait[1] = 10;
        prevRsp = rspCyc[0];
        applyStimulus(0, 1'b0, 2'b10, 5'd9, 32'h5A5A5A5A);
        n = 0;
        while (penable !== 1'b1 && n < 40) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 40) boundExpired("reach_access");
        repeat (3) @(negedge pclk);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("arst_psel", psel, 0);
        checkOutput("arst_penable", penable, 0);
        checkOutput("arst_paddr", paddr, 0);
        checkOutput("arst_pwdata", pwdata, 0);
        checkOutput("arst_rsp", {reqAccept, rspValid, rspErr}, 0);
        @(negedge pclk);
        @(negedge pclk);
        Reset = 1'b1;
        slvWait[1] = 0;
        repeat (3) @(negedge pclk);
        checkOutput("arst_no_rsp", rspCyc[0], prevRsp);
        applyStimulus(0, 1'b0, 2'b10, 5'd0, 32'h00000000);
        waitIdle("post_reset_idle", 50);
        checkOutput("post_lat", rspCyc[0] - accCyc[0], 2);
        checkOutput("post_err", lastErr[0], 2'b00);
        checkOutput("post_rd", lastRd[0], 32'h11110000);

        repeat (2) @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
